piso_serializer: RTL and testbench



---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_serializer_hold_buf.sv | 35 +++
 rtl/piso_serializer.sv | 110 +++++++++++
 tb/tb_piso_serializer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
// The FSM only distinguishes "nothing on the line" from "word in flight".
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    function automatic int piso_cw(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_hold_buf.sv
// One-entry valid/ready holding register in front of the shifter.
// The shifter drains it with load; flush discards the entry and any same-cycle write.
module piso_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             load,
    input  logic             flush,
    output logic [WIDTH-1:0] hold,
    output logic             hold_full
);

    // A drain only happens while full, so in_ready is already low and
    // a write can never coincide with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (flush) begin
            hold_full <= 1'b0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (in_valid && !hold_full) begin
            hold      <= in_data;
            hold_full <= 1'b1;
        end
    end

    assign in_ready = !hold_full;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-to-serial converter with a one-word buffer for gap-free streaming,
// tick-paced bit rate, selectable bit order and word-framing strobes.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        tick,
    input  logic                        abort,
    output logic                        sd,
    output logic                        sd_valid,
    output logic                        sd_start,
    output logic                        sd_last,
    output logic                        sd_end,
    output logic [piso_cw(WIDTH)-1:0]   bit_idx,
    output logic                        busy
);

    localparam int CW = piso_cw(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    piso_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             on_last;
    logic             load;

    assign on_last = (state == SHIFT) && (cnt == LAST);

    // Load straight away when idle, or on the tick that retires the last
    // bit so consecutive words leave no idle cycle on the line.
    assign load = !abort && hold_full && ((state == IDLE) || (tick && on_last));

    assign shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, shreg[WIDTH-1:1]};

    piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .load      (load),
        .flush     (abort),
        .hold      (hold),
        .hold_full (hold_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            sd_start <= 1'b0;
            sd_end   <= 1'b0;
        end else begin
            sd_start <= 1'b0;
            sd_end   <= 1'b0;
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (hold_full) begin
                            shreg    <= hold;
                            cnt      <= '0;
                            state    <= SHIFT;
                            sd_start <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            if (cnt == LAST) begin
                                sd_end <= 1'b1;
                                cnt    <= '0;
                                if (hold_full) begin
                                    shreg    <= hold;
                                    sd_start <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                cnt   <= cnt + 1'b1;
                                shreg <= shreg_nxt;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign sd_valid = (state == SHIFT);
    assign sd       = sd_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign sd_last  = on_last;
    assign bit_idx  = cnt;
    assign busy     = sd_valid || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: three serializer configurations, expected bit stream queued at accept
// and checked by per-instance monitors on the falling edge.
module tb_piso_serializer;
    import piso_pkg::*;

    localparam int NI = 3;
    localparam int WS [NI] = '{8, 8, 12};
    localparam bit MS [NI] = '{1'b0, 1'b1, 1'b0};

    typedef struct {
        logic b;
        int   idx;
        int   w;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] din = '0;
    logic [NI-1:0] vin = '0;
    logic        tick = 1'b0;
    logic        abort = 1'b0;

    wire  [NI-1:0] rdy, sdo, sdv, sst, slast, sde, bsy;
    logic [3:0]    bidx [NI];

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W  = WS[g];
        localparam int CW = piso_cw(W);
        logic [CW-1:0] bi;
        logic fresh;
        logic end_exp;

        piso_serializer #(.WIDTH(W), .MSB_FIRST(MS[g])) u_dut (
            .clk      (clk),
            .reset    (reset),
            .in_data  (din[W-1:0]),
            .in_valid (vin[g]),
            .in_ready (rdy[g]),
            .tick     (tick),
            .abort    (abort),
            .sd       (sdo[g]),
            .sd_valid (sdv[g]),
            .sd_start (sst[g]),
            .sd_last  (slast[g]),
            .sd_end   (sde[g]),
            .bit_idx  (bi),
            .busy     (bsy[g])
        );
        assign bidx[g] = 4'(bi);

        always @(negedge clk) begin
            if (reset) begin
                fresh   <= 1'b1;
                end_exp <= 1'b0;
            end else begin
                chk($sformatf("u%0d_sd_end", g), sde[g], end_exp);
                end_exp <= 1'b0;
                if (sdv[g]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("u%0d_extra_bit", g), 1, 0);
                    end else begin
                        chk($sformatf("u%0d_sd", g), sdo[g], exp_q[0].b);
                        chk($sformatf("u%0d_bit_idx", g), bidx[g], exp_q[0].idx);
                        chk($sformatf("u%0d_sd_last", g), slast[g], exp_q[0].idx == exp_q[0].w - 1);
                        chk($sformatf("u%0d_sd_start", g), sst[g], fresh && exp_q[0].idx == 0);
                        if (tick) begin
                            end_exp <= !abort && (exp_q[0].idx == exp_q[0].w - 1);
                            void'(exp_q.pop_front());
                            fresh <= 1'b1;
                        end else begin
                            fresh <= 1'b0;
                        end
                    end
                end else begin
                    chk($sformatf("u%0d_sd_idle", g), sdo[g], 0);
                    chk($sformatf("u%0d_start_idle", g), sst[g], 0);
                    fresh <= 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int g, input logic [11:0] d);
        for (int i = 0; i < WS[g]; i++)
            exp_q.push_back('{b: (MS[g] ? d[WS[g]-1-i] : d[i]), idx: i, w: WS[g]});
    endtask

    // Returns in the cycle after the accepting edge (word sits in hold).
    task automatic send(input int g, input logic [11:0] d);
        int n = 0;
        din = d;
        vin[g] = 1'b1;
        while (!rdy[g] && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("send_timeout", 1, 0);
        push_word(g, d);
        step();
        vin[g] = 1'b0;
    endtask

    task automatic run_count(input int g, input int n, output int c, output int t);
        logic prev;
        c = 0;
        t = 0;
        prev = sdv[g];
        repeat (n) begin
            @(negedge clk);
            if (sdv[g]) c++;
            if (sdv[g] !== prev) t++;
            prev = sdv[g];
            step();
        end
    endtask

    initial begin
        int c, t, n;

        // Reset values
        #1;
        chk("rst_ready", rdy, 3'b111);
        chk("rst_sd_valid", sdv, 0);
        chk("rst_busy", bsy, 0);
        chk("rst_bit_idx", bidx[0], 0);
        step();
        reset = 1'b0;
        tick = 1'b1;

        // LSB-first A5
        send(0, 12'h0A5);
        chk("lsb_wait_valid", sdv[0], 0);
        chk("lsb_wait_busy", bsy[0], 1);
        chk("lsb_wait_ready", rdy[0], 0);
        run_count(0, 12, c, t);
        chk("lsb_bits", c, 8);
        chk("lsb_toggles", t, 2);

        // MSB-first A5 then 0F
        send(1, 12'h0A5);
        run_count(1, 12, c, t);
        chk("msb_a5_bits", c, 8);
        send(1, 12'h00F);
        run_count(1, 12, c, t);
        chk("msb_0f_bits", c, 8);

        // Back-to-back 3C, C3 with in_valid held
        din = 12'h03C;
        vin[0] = 1'b1;
        chk("b2b_ready0", rdy[0], 1);
        push_word(0, 12'h03C);
        step();
        chk("b2b_ready_lo", rdy[0], 0);
        din = 12'h0C3;
        step();
        chk("b2b_ready_hi", rdy[0], 1);
        chk("b2b_first_valid", sdv[0], 1);
        push_word(0, 12'h0C3);
        step();
        vin[0] = 1'b0;
        chk("b2b_ready_lo2", rdy[0], 0);
        run_count(0, 20, c, t);
        chk("b2b_bits", c, 15);
        chk("b2b_toggles", t, 1);

        // Paced: tick every 3rd cycle, 12-bit word
        tick = 1'b0;
        send(2, 12'hABC);
        step();
        c = 0;
        for (int k = 0; k < 40; k++) begin
            tick = (k % 3 == 2);
            @(negedge clk);
            if (sdv[2]) c++;
            step();
        end
        chk("paced_cycles", c, 36);
        chk("queue_drained", exp_q.size(), 0);
        tick = 1'b1;

        // Abort at bit 4 with the next word held
        send(0, 12'h011);
        send(0, 12'h022);
        n = 0;
        while (bidx[0] != 4 && n < 20) begin
            step();
            n++;
        end
        chk("abort_reach_idx4", bidx[0], 4);
        chk("abort_hold_full", rdy[0], 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        chk("abort_idle", sdv[0], 0);
        chk("abort_ready", rdy[0], 1);
        chk("abort_busy", bsy[0], 0);
        chk("abort_idx", bidx[0], 0);
        run_count(0, 10, c, t);
        chk("abort_no_bits", c, 0);

        // in_valid during abort is dropped even when ready
        din = 12'h05A;
        vin[0] = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        vin[0] = 1'b0;
        chk("abort_drop_ready", rdy[0], 1);
        chk("abort_drop_busy", bsy[0], 0);
        run_count(0, 4, c, t);
        chk("abort_drop_bits", c, 0);

        // Reset mid-word
        send(0, 12'h05A);
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", rdy[0], 1);
        chk("rst_mid_sd", sdo[0], 0);
        chk("rst_mid_valid", sdv[0], 0);
        chk("rst_mid_start", sst[0], 0);
        chk("rst_mid_last", slast[0], 0);
        chk("rst_mid_end", sde[0], 0);
        chk("rst_mid_idx", bidx[0], 0);
        chk("rst_mid_busy", bsy[0], 0);
        exp_q.delete();
        step();
        reset = 1'b0;
        chk("rst_rel_ready", rdy[0], 1);
        run_count(0, 5, c, t);
        chk("rst_rel_bits", c, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
